// File: rtl/ysyx_23060184_regfile_sb.sv
// Decode-stage register file with busy scoreboard, optional writeback bypass
// and a valid/ready operand stage feeding the EXU.
module ysyx_23060184_regfile_sb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned ECALL_REG  = 15,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NREAD*ADDR_WIDTH-1:0]      in_raddr,
    input  logic [ADDR_WIDTH-1:0]            in_rd,
    input  logic                             in_rd_en,
    input  logic                             in_ecall,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NREAD*DATA_WIDTH-1:0]      out_rdata,
    output logic [ADDR_WIDTH-1:0]            out_rd,
    output logic                             out_rd_en,
    input  logic                             wb_valid,
    output logic                             wb_ready,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0]            wb_data,
    input  logic                             wb_en,
    output logic [(2**ADDR_WIDTH)-1:0]       busy
);

    localparam int unsigned AW   = ADDR_WIDTH;
    localparam int unsigned DW   = DATA_WIDTH;
    localparam int unsigned NREG = 2**ADDR_WIDTH;
    localparam logic [AW-1:0] ECALL_ADDR = AW'(ECALL_REG);
    localparam bit BYP = (BYPASS != 0);

    logic [DW-1:0]       rf [NREG];
    logic [NREG-1:0]     busy_d;
    logic [AW-1:0]       src_addr [NREAD];
    logic [NREAD*DW-1:0] rdata_c;
    logic                wb_hit;
    logic                raw_c;
    logic                waw_c;
    logic                hazard_c;
    logic                in_fire;
    logic                out_fire;

    assign wb_ready = 1'b1;
    assign wb_hit   = wb_valid & wb_en & (wb_addr != '0);

    // Source select, operand read with bypass, and RAW detection per port
    always_comb begin
        raw_c   = 1'b0;
        rdata_c = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            src_addr[k] = in_raddr[k*AW +: AW];
            if (k == 1 && in_ecall) begin
                src_addr[k] = ECALL_ADDR;
            end
            if (src_addr[k] == '0) begin
                rdata_c[k*DW +: DW] = '0;
            end else if (BYP && wb_hit && (wb_addr == src_addr[k])) begin
                rdata_c[k*DW +: DW] = wb_data;
            end else begin
                rdata_c[k*DW +: DW] = rf[src_addr[k]];
            end
            if ((src_addr[k] != '0) && busy[src_addr[k]] &&
                !(BYP && wb_hit && (wb_addr == src_addr[k]))) begin
                raw_c = 1'b1;
            end
        end
    end

    // A same-cycle writeback always releases a WAW, even without the bypass
    assign waw_c    = in_rd_en && (in_rd != '0) && busy[in_rd] &&
                      !(wb_hit && (wb_addr == in_rd));
    assign hazard_c = raw_c | waw_c;

    assign in_ready = (~out_valid | out_ready) & ~hazard_c;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_hit) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Reservation is applied after the clear so a same-index set wins
    always_comb begin
        busy_d = busy;
        if (wb_hit) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (in_fire && in_rd_en && (in_rd != '0)) begin
            busy_d[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_rd    <= '0;
            out_rd_en <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_rdata <= rdata_c;
            out_rd    <= in_rd;
            out_rd_en <= in_rd_en;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_regfile_sb.sv
// Directed bench for ysyx_23060184_regfile_sb (default parameters, bypass on);
// issued bundles are queued and compared when the operand stage hands them off.
module tb_ysyx_23060184_regfile_sb;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        rd_en;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_raddr;
    logic [4:0]  in_rd;
    logic        in_rd_en;
    logic        in_ecall;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_rd_en;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_en;
    logic [31:0] busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t exp_next;
    logic fired;

    ysyx_23060184_regfile_sb dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_raddr  (in_raddr),
        .in_rd     (in_rd),
        .in_rd_en  (in_rd_en),
        .in_ecall  (in_ecall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_rd    (out_rd),
        .out_rd_en (out_rd_en),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_en     (wb_en),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes at the falling edge, then advance to just past the rising edge
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_rdata", out_rdata, e.data);
                chk("sb_rd", 64'(out_rd), 64'(e.rd));
                chk("sb_rd_en", 64'(out_rd_en), 64'(e.rd_en));
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(exp_next);
            fired = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [63:0] data, input logic [4:0] rd, input logic rd_en);
        exp_next.data  = data;
        exp_next.rd    = rd;
        exp_next.rd_en = rd_en;
    endtask

    task automatic drive_req(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] rd,
                             input logic rd_en, input logic ecall);
        in_raddr = {a1, a0};
        in_rd    = rd;
        in_rd_en = rd_en;
        in_ecall = ecall;
        in_valid = 1'b1;
    endtask

    task automatic issue(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] rd, input logic rd_en, input logic ecall,
                         input logic [63:0] data);
        set_exp(data, rd, rd_en);
        drive_req(a0, a1, rd, rd_en, ecall);
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) cyc();
        chk({tag, "_fire"}, 64'(fired), 64'(1));
        in_valid = 1'b0;
        in_ecall = 1'b0;
        chk({tag, "_latency"}, 64'(out_valid), 64'(1));
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_en    = 1'b1;
        wb_addr  = addr;
        wb_data  = data;
    endtask

    task automatic wb_off();
        wb_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_raddr = '0; in_rd = '0; in_rd_en = 1'b0; in_ecall = 1'b0;
        out_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_en = 1'b0;
        exp_next = '0;
        fired = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("wb_ready_tied", 64'(wb_ready), 64'(1));
        reset = 1'b0;
        cyc();

        // x0 write is dropped, x0 reads as zero
        wb(5'd0, 32'hDEADBEEF);
        cyc();
        wb_off();
        chk("x0_busy", 64'(busy), 64'(0));
        issue("x0_read", 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 64'h0);
        cyc();

        // Basic write then read
        wb(5'd5, 32'h12345678);
        cyc();
        wb_off();
        issue("basic", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, {32'h0, 32'h12345678});

        // RAW stall released by the bypassed writeback
        issue("raw_a", 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 64'h0);
        chk("raw_busy_set", 64'(busy[7]), 64'(1));
        set_exp({32'h0, 32'hA5A5A5A5}, 5'd0, 1'b0);
        drive_req(5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        #2 chk("raw_stall0", 64'(in_ready), 64'(0));
        cyc();
        #2 chk("raw_stall1", 64'(in_ready), 64'(0));
        cyc();
        #2 chk("raw_stall2", 64'(in_ready), 64'(0));
        cyc();
        wb(5'd7, 32'hA5A5A5A5);
        fired = 1'b0;
        #2 chk("raw_wb_ready", 64'(in_ready), 64'(1));
        cyc();
        chk("raw_wb_fire", 64'(fired), 64'(1));
        wb_off();
        in_valid = 1'b0;
        chk("raw_busy_clr", 64'(busy[7]), 64'(0));
        cyc();

        // WAW stall, then reserve and clear of x3 in the same cycle
        issue("waw_a", 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 64'h0);
        chk("waw_busy_set", 64'(busy[3]), 64'(1));
        set_exp(64'h0, 5'd3, 1'b1);
        drive_req(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        #2 chk("waw_stall", 64'(in_ready), 64'(0));
        cyc();
        wb(5'd3, 32'h33);
        fired = 1'b0;
        #2 chk("waw_clear_ready", 64'(in_ready), 64'(1));
        cyc();
        chk("waw_fire", 64'(fired), 64'(1));
        wb_off();
        in_valid = 1'b0;
        chk("waw_set_wins", 64'(busy[3]), 64'(1));
        wb(5'd3, 32'h44);
        cyc();
        wb_off();
        chk("waw_busy_clr", 64'(busy[3]), 64'(0));
        issue("x3_read", 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, {32'h0, 32'h44});
        cyc();

        // Ecall substitutes x15 on port 1
        wb(5'd15, 32'h5D);
        cyc();
        wb_off();
        issue("ecall", 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, {32'h5D, 32'h12345678});
        cyc();

        // Backpressure: output holds, no new reservations
        out_ready = 1'b0;
        issue("bp_c", 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, {32'h0, 32'h12345678});
        set_exp({32'h12345678, 32'h44}, 5'd10, 1'b1);
        drive_req(5'd3, 5'd5, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_rdata_hold", out_rdata, {32'h0, 32'h12345678});
            chk("bp_busy", 64'(busy), 64'h200);
            cyc();
        end
        out_ready = 1'b1;
        fired = 1'b0;
        #2 chk("bp_release_ready", 64'(in_ready), 64'(1));
        cyc();
        chk("bp_d_fire", 64'(fired), 64'(1));
        in_valid = 1'b0;
        chk("bp_busy_after", 64'(busy), 64'h600);
        cyc();

        // Reset while a bundle is held discards it and all reservations
        out_ready = 1'b0;
        issue("rst_e", 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, {32'h0, 32'h12345678});
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_rdata", out_rdata, 64'h0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        wb(5'd0, 32'hDEADBEEF);
        cyc();
        wb_off();
        issue("post_rst_read", 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 64'h0);
        cyc();
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
